// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states and port indices.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } arb_state_e;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the I-cache and D-cache.
// One transaction at a time; registered request, combinational completion routing.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [DATA_W-1:0] i_req_wdata,
   input  logic              i_req_wr,
   input  logic              i_req_valid,
   output logic [DATA_W-1:0] i_req_rdata,
   output logic              i_req_ready,
   input  logic [ADDR_W-1:0] d_req_addr,
   input  logic [DATA_W-1:0] d_req_wdata,
   input  logic              d_req_wr,
   input  logic              d_req_valid,
   output logic [DATA_W-1:0] d_req_rdata,
   output logic              d_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic              mem_req_wr,
   output logic              mem_req_valid,
   input  logic [DATA_W-1:0] mem_req_data,
   input  logic              mem_req_ready,
   output logic [1:0]        grant
);

   arb_state_e        state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              wr_q, wr_d;
   logic              valid_q, valid_d;
   logic              pick_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= PORT_D;
         addr_q       <= '0;
         wdata_q      <= '0;
         wr_q         <= 1'b0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wr_q         <= wr_d;
         valid_q      <= valid_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wr_d         = wr_q;
      valid_d      = valid_q;
      // I wins when alone, or on a tie when D owned the port last.
      pick_i       = i_req_valid & (~d_req_valid | (last_grant_q == PORT_D));

      case (state_q)
         IDLE: begin
            if (pick_i) begin
               state_d      = GRANT_I;
               last_grant_d = PORT_I;
               addr_d       = i_req_addr;
               wdata_d      = i_req_wdata;
               wr_d         = i_req_wr;
               valid_d      = 1'b1;
            end else if (d_req_valid) begin
               state_d      = GRANT_D;
               last_grant_d = PORT_D;
               addr_d       = d_req_addr;
               wdata_d      = d_req_wdata;
               wr_d         = d_req_wr;
               valid_d      = 1'b1;
            end
         end
         GRANT_I, GRANT_D: begin
            // Requester dropping valid does not abort; only memory completion ends it.
            if (mem_req_ready) begin
               state_d = IDLE;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   assign mem_req_addr  = addr_q;
   assign mem_wr_data   = wdata_q;
   assign mem_req_wr    = wr_q;
   assign mem_req_valid = valid_q;

   assign i_req_rdata = mem_req_data;
   assign d_req_rdata = mem_req_data;
   assign i_req_ready = (state_q == GRANT_I) & mem_req_ready;
   assign d_req_ready = (state_q == GRANT_D) & mem_req_ready;
   assign grant       = {state_q == GRANT_D, state_q == GRANT_I};

endmodule
